// File: rtl/byte_striping.sv
// Splits a full-rate byte stream into two half-rate lanes (lane 0 = even byte,
// lane 1 = odd byte of each pair); phase_f marks which half of the pair is captured.
module byte_striping #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_BYTE = '0
) (
  input  logic             clk_2f,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_stripe_0,
  output logic [WIDTH-1:0] data_stripe_1,
  output logic             valid_stripe_0,
  output logic             valid_stripe_1,
  output logic             phase_f
);

  typedef enum logic {
    CAP0 = 1'b0,
    CAP1 = 1'b1
  } phase_t;

  phase_t           phase_reg, phase_next;
  logic [WIDTH-1:0] stage_data_reg, stage_data_next;
  logic             stage_valid_reg, stage_valid_next;
  logic [WIDTH-1:0] stripe_0_reg, stripe_0_next;
  logic [WIDTH-1:0] stripe_1_reg, stripe_1_next;
  logic             valid_0_reg, valid_0_next;
  logic             valid_1_reg, valid_1_next;
  logic [WIDTH-1:0] byte_masked;

  // Invalid bytes keep their slot but carry the idle pattern, so lanes never compact.
  assign byte_masked = valid_in ? data_in : IDLE_BYTE;

  always_ff @(posedge clk_2f) begin
    if (rst) begin
      phase_reg       <= CAP0;
      stage_data_reg  <= IDLE_BYTE;
      stage_valid_reg <= 1'b0;
      stripe_0_reg    <= IDLE_BYTE;
      stripe_1_reg    <= IDLE_BYTE;
      valid_0_reg     <= 1'b0;
      valid_1_reg     <= 1'b0;
    end else begin
      phase_reg       <= phase_next;
      stage_data_reg  <= stage_data_next;
      stage_valid_reg <= stage_valid_next;
      stripe_0_reg    <= stripe_0_next;
      stripe_1_reg    <= stripe_1_next;
      valid_0_reg     <= valid_0_next;
      valid_1_reg     <= valid_1_next;
    end
  end

  always_comb begin
    phase_next       = phase_reg;
    stage_data_next  = stage_data_reg;
    stage_valid_next = stage_valid_reg;
    stripe_0_next    = stripe_0_reg;
    stripe_1_next    = stripe_1_reg;
    valid_0_next     = valid_0_reg;
    valid_1_next     = valid_1_reg;
    case (phase_reg)
      CAP0: begin
        stage_data_next  = byte_masked;
        stage_valid_next = valid_in;
        phase_next       = CAP1;
      end
      CAP1: begin
        // Both lanes load together so the pair presents with no inter-lane skew.
        stripe_0_next = stage_data_reg;
        valid_0_next  = stage_valid_reg;
        stripe_1_next = byte_masked;
        valid_1_next  = valid_in;
        phase_next    = CAP0;
      end
      default: phase_next = CAP0;
    endcase
  end

  assign data_stripe_0  = stripe_0_reg;
  assign data_stripe_1  = stripe_1_reg;
  assign valid_stripe_0 = valid_0_reg;
  assign valid_stripe_1 = valid_1_reg;
  assign phase_f        = phase_reg;

endmodule

// File: tb/tb_byte_striping.sv
// Random and directed stimulus for byte_striping, checked against a pair-history
// model and an in-bench unstripping loopback.
module tb_byte_striping;

  logic       clk_2f = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;

  logic [7:0] a_d0, a_d1, b_d0, b_d1;
  logic       a_v0, a_v1, a_ph, b_v0, b_v1, b_ph;

  byte_striping #(.WIDTH(8), .IDLE_BYTE(8'h00)) dut_a (
    .clk_2f(clk_2f), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .data_stripe_0(a_d0), .data_stripe_1(a_d1),
    .valid_stripe_0(a_v0), .valid_stripe_1(a_v1), .phase_f(a_ph)
  );

  byte_striping #(.WIDTH(8), .IDLE_BYTE(8'hBC)) dut_b (
    .clk_2f(clk_2f), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .data_stripe_0(b_d0), .data_stripe_1(b_d1),
    .valid_stripe_0(b_v0), .valid_stripe_1(b_v1), .phase_f(b_ph)
  );

  always #5 clk_2f = ~clk_2f;

  int         vectors = 0;
  int         miscompares = 0;
  int         k = 0;            // edges since reset released
  logic [7:0] hist_d[$];
  logic       hist_v[$];
  logic [8:0] sent[$];          // {valid, masked data} for loopback
  logic       loop_on = 1'b0;

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Stripes are the pair of stream bytes (2m, 2m+1) with m = k/2 - 1, or reset values before the first pair.
  task automatic check_lanes(input string name, input logic [7:0] idle,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic v0, input logic v1, input logic ph);
    logic [7:0] e_d0, e_d1;
    logic       e_v0, e_v1;
    int         m;
    e_d0 = idle; e_d1 = idle; e_v0 = 1'b0; e_v1 = 1'b0;
    if (k >= 2) begin
      m    = ((k / 2) - 1) * 2;
      e_v0 = hist_v[m];
      e_v1 = hist_v[m+1];
      e_d0 = hist_v[m] ? hist_d[m] : idle;
      e_d1 = hist_v[m+1] ? hist_d[m+1] : idle;
    end
    check_value({name, "_phase"}, {15'd0, ph}, {15'd0, k[0]});
    check_value({name, "_v0"}, {15'd0, v0}, {15'd0, e_v0});
    check_value({name, "_v1"}, {15'd0, v1}, {15'd0, e_v1});
    check_value({name, "_d0"}, {8'd0, d0}, {8'd0, e_d0});
    check_value({name, "_d1"}, {8'd0, d1}, {8'd0, e_d1});
  endtask

  task automatic step(input logic r, input logic [7:0] d, input logic v);
    logic [8:0] exp_pair;
    rst = r; data_in = d; valid_in = v;
    @(posedge clk_2f);
    #1;
    if (r) begin
      hist_d.delete(); hist_v.delete(); k = 0;
    end else begin
      hist_d.push_back(d); hist_v.push_back(v); k++;
      if (loop_on) sent.push_back({v, v ? d : 8'h00});
    end
    check_lanes("a", 8'h00, a_d0, a_d1, a_v0, a_v1, a_ph);
    check_lanes("b", 8'hBC, b_d0, b_d1, b_v0, b_v1, b_ph);
    // Unstripping view: at each new pair, lane 0 then lane 1 must match the next sent bytes.
    if (loop_on && !r && k >= 2 && k[0] == 1'b0) begin
      exp_pair = (sent.size() > 0) ? sent.pop_front() : 9'h1FF;
      check_value("loop_lane0", {7'd0, a_v0, a_d0}, {7'd0, exp_pair});
      exp_pair = (sent.size() > 0) ? sent.pop_front() : 9'h1FF;
      check_value("loop_lane1", {7'd0, a_v1, a_d1}, {7'd0, exp_pair});
    end
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'($urandom), 1'($urandom));
      check_value("rst_phase", {15'd0, a_ph}, 16'd0);
    end

    // Full-rate stream
    step(1'b0, 8'h11, 1'b1);
    step(1'b0, 8'h22, 1'b1);
    check_value("full_d0_p0", {8'd0, a_d0}, 16'h0011);
    check_value("full_d1_p0", {8'd0, a_d1}, 16'h0022);
    step(1'b0, 8'h33, 1'b1);
    check_value("full_hold_d0", {8'd0, a_d0}, 16'h0011);
    step(1'b0, 8'h44, 1'b1);
    check_value("full_d0_p1", {8'd0, a_d0}, 16'h0033);
    check_value("full_d1_p1", {8'd0, a_d1}, 16'h0044);

    // Gap in lane 1
    step(1'b0, 8'hA5, 1'b1);
    step(1'b0, 8'hFF, 1'b0);
    check_value("gap_d0", {8'd0, a_d0}, 16'h00A5);
    check_value("gap_v1", {15'd0, a_v1}, 16'd0);
    check_value("gap_d1", {8'd0, a_d1}, 16'h0000);

    // Reset mid-pair
    step(1'b0, 8'h5A, 1'b1);
    step(1'b1, 8'h66, 1'b1);
    check_value("midrst_v0", {15'd0, a_v0}, 16'd0);
    check_value("midrst_d0", {8'd0, a_d0}, 16'h0000);
    step(1'b0, 8'h77, 1'b1);
    step(1'b0, 8'h88, 1'b1);
    check_value("midrst_lane0", {8'd0, a_d0}, 16'h0077);
    check_value("midrst_lane1", {8'd0, a_d1}, 16'h0088);

    // Idle-byte variant: 3 all-invalid pairs
    step(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'($urandom), 1'b0);
      if (i % 2 == 1) begin
        check_value("idle_b_d0", {8'd0, b_d0}, 16'h00BC);
        check_value("idle_b_d1", {8'd0, b_d1}, 16'h00BC);
      end
    end

    // Loopback with ~20% invalid bytes
    step(1'b1, 8'h00, 1'b0);
    loop_on = 1'b1;
    for (int i = 0; i < 256; i++)
      step(1'b0, 8'($urandom), ($urandom_range(0, 99) >= 20) ? 1'b1 : 1'b0);
    loop_on = 1'b0;
    check_value("loop_drained", 16'(sent.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
